// File: rtl/cmp_pkg.sv
// Shared types for the magnitude-comparator interface: search FSM states,
// decoded comparator verdicts and the flag-to-verdict decoder.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        V_GT  = 2'd0,
        V_LT  = 2'd1,
        V_EQ  = 2'd2,
        V_BAD = 2'd3
    } verdict_t;

    // Exactly one flag set gives a real verdict; anything else is malformed.
    function automatic verdict_t decode_verdict(input logic a_grt,
                                                input logic b_grt,
                                                input logic a_eq_b);
        verdict_t v;
        case ({a_grt, b_grt, a_eq_b})
            3'b100:  v = V_GT;
            3'b010:  v = V_LT;
            3'b001:  v = V_EQ;
            default: v = V_BAD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sar_rsp_timer.sv
// Saturating response-timeout counter. Cleared outside the wait phase,
// counts each enabled cycle, and flags expiry on the enabled cycle that
// brings the count up to TIMEOUT so the waiter leaves after exactly
// TIMEOUT silent cycles.
module sar_rsp_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    // Count silent cycles, holding at TIMEOUT rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_W'(TIMEOUT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = en && !clr && (count_reg >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search engine. Presents trial values to an
// external comparator, MSB first, and refines the trial from each
// greater/less/equal verdict until the target is resolved, an equal
// verdict arrives early, or the comparator misbehaves or goes silent.
module sar_search_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found_exact,
    output logic             err,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [WIDTH-1:0] q_trial,
    input  logic             rsp_valid,
    input  logic             rsp_a_grt,
    input  logic             rsp_b_grt,
    input  logic             rsp_a_eq_b
);
    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] trial_reg;
    logic [WIDTH-1:0] result_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             found_reg;
    logic             err_reg;

    verdict_t         verdict;
    logic [WIDTH-1:0] trial_upd;
    logic [WIDTH-1:0] trial_step;
    logic             last_bit;
    logic             timer_clr;
    logic             timer_en;
    logic             timer_expired;

    // Decode the verdict and form both the settled trial (current bit
    // resolved) and the next trial (next lower bit tentatively set).
    always_comb begin
        verdict   = decode_verdict(rsp_a_grt, rsp_b_grt, rsp_a_eq_b);
        trial_upd = trial_reg;
        if (verdict == V_GT) begin
            trial_upd[idx_reg] = 1'b0;
        end
        trial_step = trial_upd;
        if (idx_reg != '0) begin
            trial_step[idx_reg - 1'b1] = 1'b1;
        end
    end

    assign last_bit  = (idx_reg == '0);
    assign timer_clr = (state_reg != WAIT);
    assign timer_en  = (state_reg == WAIT) && !rsp_valid;

    sar_rsp_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_rsp_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Search sequencer: query handshake, verdict consumption, and the
    // held result/status registers reported with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            trial_reg  <= '0;
            idx_reg    <= IDX_W'(WIDTH - 1);
            result_reg <= '0;
            found_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        trial_reg <= MSB_ONLY;
                        idx_reg   <= IDX_W'(WIDTH - 1);
                        found_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (q_ready) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        case (verdict)
                            V_EQ: begin
                                result_reg <= trial_reg;
                                found_reg  <= 1'b1;
                                state_reg  <= DONE;
                            end
                            V_BAD: begin
                                result_reg <= trial_reg;
                                err_reg    <= 1'b1;
                                state_reg  <= DONE;
                            end
                            default: begin
                                if (last_bit) begin
                                    trial_reg  <= trial_upd;
                                    result_reg <= trial_upd;
                                    state_reg  <= DONE;
                                end else begin
                                    trial_reg  <= trial_step;
                                    idx_reg    <= idx_reg - 1'b1;
                                    state_reg  <= REQ;
                                end
                            end
                        endcase
                    end else if (timer_expired) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_reg == REQ) || (state_reg == WAIT);
    assign done        = (state_reg == DONE);
    assign q_valid     = (state_reg == REQ);
    assign q_trial     = trial_reg;
    assign result      = result_reg;
    assign found_exact = found_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl. Each search is planned up front
// as a per-cycle timeline: the expected trial for query k is the target's
// upper bits with a marker bit appended, verdicts come from plain
// magnitude comparison, and stalls/latencies/faults are drawn at random.
// The timeline carries both the inputs to drive and the outputs to expect.
module tb_sar_search_ctrl;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         q_ready = 1'b0;
    logic         rsp_valid = 1'b0;
    logic         rsp_a_grt = 1'b0;
    logic         rsp_b_grt = 1'b0;
    logic         rsp_a_eq_b = 1'b0;
    logic         busy, done, q_valid, found_exact, err;
    logic [W-1:0] result, q_trial;

    int checks = 0;
    int errors = 0;

    sar_search_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .found_exact (found_exact),
        .err         (err),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q_trial     (q_trial),
        .rsp_valid   (rsp_valid),
        .rsp_a_grt   (rsp_a_grt),
        .rsp_b_grt   (rsp_b_grt),
        .rsp_a_eq_b  (rsp_a_eq_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         st, rdy, rv, ag, bg, eq;
        logic         e_busy, e_done, e_qv;
        logic [W-1:0] e_trial, e_res;
        logic         e_fnd, e_err;
    } cyc_t;

    cyc_t         plan[$];
    logic [W-1:0] m_result = '0;
    logic         m_found = 1'b0;
    logic         m_err = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Query k probes bit p = W-1-k: target bits above p kept, bit p set, rest clear.
    function automatic logic [W-1:0] exp_trial(input logic [W-1:0] t, input int k);
        logic [W-1:0] v;
        int p;
        p = W - 1 - k;
        v = t >> p;
        v[0] = 1'b1;
        return v << p;
    endfunction

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.st = 1'b0; c.rdy = 1'b0; c.rv = 1'b0; c.ag = 1'b0; c.bg = 1'b0; c.eq = 1'b0;
        c.e_busy = 1'b0; c.e_done = 1'b0; c.e_qv = 1'b0; c.e_trial = '0;
        c.e_res = m_result; c.e_fnd = m_found; c.e_err = m_err;
        return c;
    endfunction

    task automatic add_idle(input int n, input bit junk);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = idle_cyc();
            if (junk) begin
                c.rv = 1'($urandom_range(1, 0));
                {c.ag, c.bg, c.eq} = 3'($urandom_range(7, 0));
            end
            plan.push_back(c);
        end
    endtask

    task automatic push_busy(input logic qv, input logic [W-1:0] t, input logic rdy,
                             input bit junk, input logic rv, input logic [2:0] fl);
        cyc_t c;
        c = idle_cyc();
        c.e_busy = 1'b1; c.e_qv = qv; c.e_trial = t; c.rdy = rdy;
        c.st = 1'($urandom_range(1, 0));
        if (junk) begin
            c.rv = 1'($urandom_range(1, 0));
            {c.ag, c.bg, c.eq} = 3'($urandom_range(7, 0));
        end else begin
            c.rv = rv;
            {c.ag, c.bg, c.eq} = fl;
        end
        plan.push_back(c);
    endtask

    // fault_kind 0: malformed flags on query fault_q; 1: no response on query fault_q.
    task automatic build_search(input logic [W-1:0] tgt, input int max_stall, input int max_delay,
                                input int fault_q, input int fault_kind, input logic [2:0] bad_flags);
        cyc_t c;
        logic [W-1:0] t;
        int s, d;
        c = idle_cyc();
        c.st = 1'b1;
        plan.push_back(c);
        m_found = 1'b0;
        m_err   = 1'b0;
        for (int k = 0; k < W; k++) begin
            t = exp_trial(tgt, k);
            s = $urandom_range(max_stall, 0);
            d = $urandom_range(max_delay, 1);
            for (int j = 0; j <= s; j++) push_busy(1'b1, t, (j == s), 1'b1, 1'b0, 3'b000);
            if (fault_q == k && fault_kind == 1) begin
                for (int j = 0; j < TO; j++) push_busy(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
                m_err = 1'b1;
                break;
            end
            for (int j = 0; j < d - 1; j++) push_busy(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
            if (fault_q == k) begin
                push_busy(1'b0, '0, 1'b0, 1'b0, 1'b1, bad_flags);
                m_err    = 1'b1;
                m_result = t;
                break;
            end
            push_busy(1'b0, '0, 1'b0, 1'b0, 1'b1, {(t > tgt), (t < tgt), (t == tgt)});
            if (t == tgt || k == W - 1) begin
                m_result = tgt;
                m_found  = (t == tgt);
                break;
            end
        end
        c = idle_cyc();
        c.e_done = 1'b1;
        c.st = 1'($urandom_range(1, 0));
        plan.push_back(c);
    endtask

    // Per-cycle compare against the plan, then drive that cycle's inputs.
    task automatic run_plan(input int n);
        cyc_t c;
        for (int i = 0; i < n && plan.size() > 0; i++) begin
            c = plan.pop_front();
            @(negedge clk);
            check("busy", 8'(busy), 8'(c.e_busy));
            check("done", 8'(done), 8'(c.e_done));
            check("q_valid", 8'(q_valid), 8'(c.e_qv));
            if (c.e_qv) check("q_trial", q_trial, c.e_trial);
            check("result", result, c.e_res);
            check("found_exact", 8'(found_exact), 8'(c.e_fnd));
            check("err", 8'(err), 8'(c.e_err));
            start = c.st; q_ready = c.rdy; rsp_valid = c.rv;
            rsp_a_grt = c.ag; rsp_b_grt = c.bg; rsp_a_eq_b = c.eq;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 8'(busy), 8'h00);
        check({tag, "_done"}, 8'(done), 8'h00);
        check({tag, "_q_valid"}, 8'(q_valid), 8'h00);
        check({tag, "_q_trial"}, q_trial, 8'h00);
        check({tag, "_result"}, result, 8'h00);
        check({tag, "_found"}, 8'(found_exact), 8'h00);
        check({tag, "_err"}, 8'(err), 8'h00);
    endtask

    initial begin
        logic [W-1:0] lit_5a [7];
        logic [2:0]   bad_set [5];
        int           n0;
        int           r;
        logic [W-1:0] tgt;
        lit_5a  = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        bad_set = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};

        // Hand-computed pins on the trial model.
        for (int k = 0; k < 7; k++) check("pin_trial_5a", exp_trial(8'h5A, k), lit_5a[k]);
        check("pin_trial_00_last", exp_trial(8'h00, 7), 8'h01);
        check("pin_trial_ff_last", exp_trial(8'hFF, 7), 8'hFF);

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        add_idle(3, 1'b1);
        run_plan(plan.size());

        build_search(8'h5A, 0, 1, -1, 0, 3'b000);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("t5a_result", result, 8'h5A);
        check("t5a_found", 8'(found_exact), 8'h01);

        n0 = plan.size();
        build_search(8'h00, 0, 1, -1, 0, 3'b000);
        check("pin_00_start_to_done", 8'(plan.size() - 1 - n0), 8'd17);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("t00_result", result, 8'h00);
        check("t00_found", 8'(found_exact), 8'h00);

        build_search(8'hFF, 3, 1, -1, 0, 3'b000);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("tff_result", result, 8'hFF);
        check("tff_found", 8'(found_exact), 8'h01);

        build_search(8'h5A, 0, 1, 0, 0, 3'b110);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("tbad_err", 8'(err), 8'h01);
        check("tbad_result", result, 8'h80);

        build_search(8'h5A, 0, 1, 0, 1, 3'b000);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("tto_err", 8'(err), 8'h01);

        build_search(8'h33, 0, 1, -1, 0, 3'b000);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("t33_result", result, 8'h33);
        check("t33_err", 8'(err), 8'h00);

        // Randomised searches with stalls, slow responses and occasional faults.
        for (int i = 0; i < 40; i++) begin
            tgt = 8'($urandom_range(255, 0));
            r = $urandom_range(9, 0);
            if (r == 0)
                build_search(tgt, 3, 3, $urandom_range(W - 1, 0), 0, bad_set[$urandom_range(4, 0)]);
            else if (r == 1)
                build_search(tgt, 3, 3, $urandom_range(W - 1, 0), 1, 3'b000);
            else
                build_search(tgt, 3, 3, -1, 0, 3'b000);
            add_idle($urandom_range(3, 0), 1'b1);
        end
        add_idle(1, 1'b0);
        run_plan(plan.size());

        // Reset asserted during the 4th WAIT cycle of a search.
        build_search(8'h5A, 0, 1, -1, 0, 3'b000);
        run_plan(9);
        plan.delete();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_no_done", 8'(done), 8'h00);
            check("midrst_busy", 8'(busy), 8'h00);
        end
        start = 1'b0; q_ready = 1'b0; rsp_valid = 1'b0;
        rsp_a_grt = 1'b0; rsp_b_grt = 1'b0; rsp_a_eq_b = 1'b0;
        rst_n = 1'b1;
        m_result = '0; m_found = 1'b0; m_err = 1'b0;
        add_idle(3, 1'b1);
        build_search(8'hA7, 2, 2, -1, 0, 3'b000);
        add_idle(2, 1'b0);
        run_plan(plan.size());
        check("post_rst_result", result, 8'hA7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search engine. It is the initiator side of the magnitude-comparator interface: it drives trial values to an external comparator and consumes its greater / less / equal verdicts.
- It resolves an unknown WIDTH-bit target, MSB first, in at most WIDTH queries.
- It sits between a host that issues start/done and a comparator responder, such as a comparator with a registered response stage.

Parameters:
- WIDTH, 8, width of the trial value and the result.
- TIMEOUT, 16, maximum cycles to wait for rsp_valid after a query is accepted; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the search ends (success or error).
- result  out  WIDTH  final value; valid while done is high, held until the next start.
- found_exact  out  1  an equal verdict was received during this search; valid with done.
- err  out  1  search aborted (bad verdict or timeout); valid with done.
- q_valid  out  1  a query is presented.
- q_ready  in  1  the comparator accepts the query.
- q_trial  out  WIDTH  trial value (comparator operand A; the target is operand B).
- rsp_valid  in  1  verdict flags valid this cycle.
- rsp_a_grt  in  1  trial > target.
- rsp_b_grt  in  1  trial < target.
- rsp_a_eq_b  in  1  trial == target.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0; state IDLE; trial register 0; bit index WIDTH-1; timer 0. Asserting rst_n low mid-search aborts immediately, with no done pulse.
- State IDLE:
  - start → trial = 1<<(WIDTH-1), idx = WIDTH-1, go to REQ.
  - start is ignored in every other state.
- State REQ:
  - q_valid = 1 and q_trial = trial, both stable until q_ready.
  - On q_valid & q_ready → go to WAIT, timer cleared.
  - No timeout applies in REQ.
- State WAIT:
  - q_valid = 0. Responses are sampled only in WAIT; rsp_valid in any other state is ignored.
  - rsp_valid with exactly one flag set:
    - a_eq_b: result = trial, found_exact = 1 → DONE.
    - a_grt: clear bit idx of trial.
    - b_grt: keep bit idx.
  - Then, if idx == 0: result = trial after the update → DONE.
  - Otherwise: idx = idx-1, set the new bit idx in trial → REQ.
  - rsp_valid with zero or more than one flag set: err = 1, result = trial → DONE.
  - Timer increments each WAIT cycle without rsp_valid. When the timer reaches TIMEOUT: err = 1 → DONE.
- State DONE: done = 1 for exactly one cycle, busy = 0, then → IDLE. result, found_exact and err are held until the next accepted start, which clears found_exact and err.
- Latency:
  - Per query: 1 REQ cycle minimum + at least 1 WAIT cycle.
  - With q_ready tied high and a 1-cycle response: 2 cycles per bit, start-to-done = 2·WIDTH + 1 cycles worst case.
  - An equal verdict terminates early.
- Width rules:
  - idx is $clog2(WIDTH) bits.
  - The timer is $clog2(TIMEOUT+1) bits and saturates.
  - No arithmetic beyond single-bit set/clear.
- Boundaries:
  - Target 0 never yields an equal verdict (the last trial is 1, answered greater): result 0, found_exact 0.
  - Target all-ones yields equal on the final query.
  - rsp_valid in the same cycle as the query handshake belongs to no query and is ignored.

Decomposition:
- Shared package cmp_pkg:
  - state enum {IDLE, REQ, WAIT, DONE};
  - verdict enum {V_GT, V_LT, V_EQ, V_BAD};
  - function decode_verdict(a_grt, b_grt, a_eq_b) returning that enum. The comparator testbench reuses it.
- One sub-module: sar_rsp_timer, the saturating timeout counter with clear/enable inputs and an expired output.

Test Plan:
- WIDTH=8, target 0x5A, q_ready=1, 1-cycle model → trials 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A; done after the 7th verdict; result 0x5A, found_exact 1, err 0.
- Target 0x00 → 8 queries, each answered greater (0x80 … 0x01); result 0x00, found_exact 0, err 0; start-to-done 17 cycles.
- Target 0xFF with q_ready low for 3 cycles on each query → q_trial stable while stalled; last trial 0xFF answered equal; result 0xFF, found_exact 1.
- Respond to the first query with a_grt = b_grt = 1 → done on that cycle + 1 DONE cycle; err 1, result 0x80.
- Withhold rsp_valid after the first handshake → err 1 exactly TIMEOUT (16) WAIT cycles later; then start again with target 0x33 → result 0x33, err cleared.
- Pulse rst_n low during the 4th WAIT cycle → all outputs 0 asynchronously, no done pulse; start during busy and rsp_valid in IDLE are both ignored.
